// File: rtl/cpu_defs.sv
// Shared definitions for the decode stage: sizes, opcode map, instruction field
// positions and the opcode-to-class decoder.
package cpu_defs;

    localparam int NREGS   = 16;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 4;
    localparam int OP_W    = 6;
    localparam int IMM_W   = 30;

    localparam logic [5:0] OP_NOP    = 6'h00;
    localparam logic [5:0] OP_ALU_LO = 6'h01;
    localparam logic [5:0] OP_ALU_HI = 6'h0F;
    localparam logic [5:0] OP_LD     = 6'h10;
    localparam logic [5:0] OP_ST     = 6'h11;
    localparam logic [5:0] OP_BR     = 6'h20;
    localparam logic [5:0] OP_JMP    = 6'h21;

    localparam int OP_MSB  = 47;
    localparam int OP_LSB  = 42;
    localparam int RD_MSB  = 41;
    localparam int RD_LSB  = 38;
    localparam int RS_MSB  = 37;
    localparam int RS_LSB  = 34;
    localparam int RT_MSB  = 33;
    localparam int RT_LSB  = 30;
    localparam int IMM_MSB = 29;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic illegal;
        logic reads_rs;
        logic reads_rt;
        logic writes_rd;
    } dec_ctl_t;

    // Illegal opcodes decode to a NOP that only raises the illegal flag.
    function automatic dec_ctl_t decode_op(input logic [OP_W-1:0] op);
        dec_ctl_t ctl;
        ctl = '0;
        if (op == OP_NOP) begin
            ctl = '0;
        end else if (op >= OP_ALU_LO && op <= OP_ALU_HI) begin
            ctl.is_alu    = 1'b1;
            ctl.reads_rs  = 1'b1;
            ctl.reads_rt  = 1'b1;
            ctl.writes_rd = 1'b1;
        end else if (op == OP_LD) begin
            ctl.is_load   = 1'b1;
            ctl.reads_rs  = 1'b1;
            ctl.writes_rd = 1'b1;
        end else if (op == OP_ST) begin
            ctl.is_store  = 1'b1;
            ctl.reads_rs  = 1'b1;
            ctl.reads_rt  = 1'b1;
        end else if (op == OP_BR) begin
            ctl.is_branch = 1'b1;
            ctl.reads_rs  = 1'b1;
            ctl.reads_rt  = 1'b1;
        end else if (op == OP_JMP) begin
            ctl.is_jump   = 1'b1;
        end else begin
            ctl.illegal   = 1'b1;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: two combinational read ports with write-through
// bypass from the single write port; r0 reads as zero and is never written.
module cpu_regfile
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [XLEN-1:0]   rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] regs_r [NREGS];

    function automatic logic [XLEN-1:0] read_port(
        input logic [REG_AW-1:0] addr,
        input logic              we,
        input logic [REG_AW-1:0] waddr,
        input logic [XLEN-1:0]   wdata,
        input logic [XLEN-1:0]   stored
    );
        logic [XLEN-1:0] val;
        if (addr == {REG_AW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en && (wr_addr != {REG_AW{1'b0}})) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports with bypass.
    always_comb begin
        rd_data_a = read_port(rd_addr_a, wr_en, wr_addr, wr_data, regs_r[rd_addr_a]);
        rd_data_b = read_port(rd_addr_b, wr_en, wr_addr, wr_data, regs_r[rd_addr_b]);
    end

endmodule

// File: rtl/cpu_decode.sv
// Pipeline stage 2: decodes the fetched instruction, reads operands and holds
// the 2a pipeline register; stalls fetch on load-use hazards.
module cpu_decode
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic [47:0]       instruction_1a,
    input  logic [XLEN-1:0]   pc_1a,
    input  logic              kill_4a,
    output logic              stall_2a,
    input  logic              wb_en_5a,
    input  logic [REG_AW-1:0] wb_rd_5a,
    input  logic [XLEN-1:0]   wb_data_5a,
    output logic              valid_2a,
    output logic [XLEN-1:0]   pc_2a,
    output logic [OP_W-1:0]   opcode_2a,
    output logic [REG_AW-1:0] rd_2a,
    output logic [REG_AW-1:0] rs_2a,
    output logic [REG_AW-1:0] rt_2a,
    output logic [XLEN-1:0]   rs_val_2a,
    output logic [XLEN-1:0]   rt_val_2a,
    output logic [XLEN-1:0]   imm_2a,
    output logic              is_alu_2a,
    output logic              is_load_2a,
    output logic              is_store_2a,
    output logic              is_branch_2a,
    output logic              is_jump_2a,
    output logic              writes_rd_2a,
    output logic              illegal_2a
);

    logic [OP_W-1:0]   opcode_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   rs_val_s;
    logic [XLEN-1:0]   rt_val_s;
    dec_ctl_t          dec_s;
    logic              writes_rd_s;
    logic              rs_hit_s;
    logic              rt_hit_s;
    logic              hazard_s;

    logic              valid_1a_r;
    logic              ld_v_3a_r;
    logic [REG_AW-1:0] ld_rd_3a_r;

    assign opcode_s    = instruction_1a[OP_MSB:OP_LSB];
    assign rd_s        = instruction_1a[RD_MSB:RD_LSB];
    assign rs_s        = instruction_1a[RS_MSB:RS_LSB];
    assign rt_s        = instruction_1a[RT_MSB:RT_LSB];
    assign imm_s       = {{(XLEN-IMM_W){instruction_1a[IMM_MSB]}}, instruction_1a[IMM_MSB:0]};
    assign dec_s       = decode_op(opcode_s);
    assign writes_rd_s = dec_s.writes_rd && (rd_s != {REG_AW{1'b0}});

    cpu_regfile u_regfile (
        .clk       (clk),
        .rst_b     (rst_b),
        .rd_addr_a (rs_s),
        .rd_data_a (rs_val_s),
        .rd_addr_b (rt_s),
        .rd_data_b (rt_val_s),
        .wr_en     (wb_en_5a),
        .wr_addr   (wb_rd_5a),
        .wr_data   (wb_data_5a)
    );

    // A source conflicts with a load still in 2a or in its 3a shadow.
    always_comb begin
        rs_hit_s = dec_s.reads_rs && (rs_s != {REG_AW{1'b0}}) &&
                   ((valid_2a && is_load_2a && writes_rd_2a && (rd_2a == rs_s)) ||
                    (ld_v_3a_r && (ld_rd_3a_r == rs_s)));
        rt_hit_s = dec_s.reads_rt && (rt_s != {REG_AW{1'b0}}) &&
                   ((valid_2a && is_load_2a && writes_rd_2a && (rd_2a == rt_s)) ||
                    (ld_v_3a_r && (ld_rd_3a_r == rt_s)));
        hazard_s = valid_1a_r && (rs_hit_s || rt_hit_s);
        stall_2a = hazard_s && !kill_4a;
    end

    // Stage state: 1a valid, load shadow and the 2a pipeline register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_1a_r   <= 1'b0;
            ld_v_3a_r    <= 1'b0;
            ld_rd_3a_r   <= {REG_AW{1'b0}};
            valid_2a     <= 1'b0;
            pc_2a        <= {XLEN{1'b0}};
            opcode_2a    <= {OP_W{1'b0}};
            rd_2a        <= {REG_AW{1'b0}};
            rs_2a        <= {REG_AW{1'b0}};
            rt_2a        <= {REG_AW{1'b0}};
            rs_val_2a    <= {XLEN{1'b0}};
            rt_val_2a    <= {XLEN{1'b0}};
            imm_2a       <= {XLEN{1'b0}};
            is_alu_2a    <= 1'b0;
            is_load_2a   <= 1'b0;
            is_store_2a  <= 1'b0;
            is_branch_2a <= 1'b0;
            is_jump_2a   <= 1'b0;
            writes_rd_2a <= 1'b0;
            illegal_2a   <= 1'b0;
        end else begin
            valid_1a_r <= 1'b1;

            if (kill_4a) begin
                ld_v_3a_r <= 1'b0;
            end else if (valid_2a) begin
                ld_v_3a_r  <= is_load_2a;
                ld_rd_3a_r <= rd_2a;
            end else begin
                ld_v_3a_r <= 1'b0;
            end

            // Kill and stall both leave a bubble; data fields are simply held.
            if (kill_4a || stall_2a) begin
                valid_2a     <= 1'b0;
                is_alu_2a    <= 1'b0;
                is_load_2a   <= 1'b0;
                is_store_2a  <= 1'b0;
                is_branch_2a <= 1'b0;
                is_jump_2a   <= 1'b0;
                writes_rd_2a <= 1'b0;
                illegal_2a   <= 1'b0;
            end else begin
                valid_2a     <= valid_1a_r;
                pc_2a        <= pc_1a;
                opcode_2a    <= opcode_s;
                rd_2a        <= rd_s;
                rs_2a        <= rs_s;
                rt_2a        <= rt_s;
                rs_val_2a    <= rs_val_s;
                rt_val_2a    <= rt_val_s;
                imm_2a       <= imm_s;
                is_alu_2a    <= valid_1a_r && dec_s.is_alu;
                is_load_2a   <= valid_1a_r && dec_s.is_load;
                is_store_2a  <= valid_1a_r && dec_s.is_store;
                is_branch_2a <= valid_1a_r && dec_s.is_branch;
                is_jump_2a   <= valid_1a_r && dec_s.is_jump;
                writes_rd_2a <= valid_1a_r && writes_rd_s;
                illegal_2a   <= valid_1a_r && dec_s.illegal;
            end
        end
    end

endmodule

// File: tb/tb_cpu_decode.sv
// Self-checking bench for cpu_decode: directed scenarios plus randomized traffic
// compared every cycle against a behavioural pipeline model.
module tb_cpu_decode;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [47:0] instruction_1a;
    logic [31:0] pc_1a;
    logic        kill_4a;
    logic        stall_2a;
    logic        wb_en_5a;
    logic [3:0]  wb_rd_5a;
    logic [31:0] wb_data_5a;
    logic        valid_2a;
    logic [31:0] pc_2a;
    logic [5:0]  opcode_2a;
    logic [3:0]  rd_2a, rs_2a, rt_2a;
    logic [31:0] rs_val_2a, rt_val_2a, imm_2a;
    logic        is_alu_2a, is_load_2a, is_store_2a, is_branch_2a, is_jump_2a;
    logic        writes_rd_2a, illegal_2a;

    always #5 clk = ~clk;

    cpu_decode dut (
        .clk(clk), .rst_b(rst_b), .instruction_1a(instruction_1a), .pc_1a(pc_1a),
        .kill_4a(kill_4a), .stall_2a(stall_2a), .wb_en_5a(wb_en_5a),
        .wb_rd_5a(wb_rd_5a), .wb_data_5a(wb_data_5a), .valid_2a(valid_2a),
        .pc_2a(pc_2a), .opcode_2a(opcode_2a), .rd_2a(rd_2a), .rs_2a(rs_2a),
        .rt_2a(rt_2a), .rs_val_2a(rs_val_2a), .rt_val_2a(rt_val_2a), .imm_2a(imm_2a),
        .is_alu_2a(is_alu_2a), .is_load_2a(is_load_2a), .is_store_2a(is_store_2a),
        .is_branch_2a(is_branch_2a), .is_jump_2a(is_jump_2a),
        .writes_rd_2a(writes_rd_2a), .illegal_2a(illegal_2a)
    );

    // Model of what 2a must hold; class 0 nop,1 alu,2 ld,3 st,4 br,5 jmp,6 illegal.
    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  rd, rs, rt;
        logic [31:0] rsv, rtv, imm;
        int          cls;
        bit          wr;
    } slot_t;

    slot_t       e;
    logic [31:0] mregs [16];
    bit          m_v1, m_ldv, m_hold, chk_en;
    logic [3:0]  m_ldrd;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'h00) return 0;
        if (op <= 6'h0F) return 1;
        if (op == 6'h10) return 2;
        if (op == 6'h11) return 3;
        if (op == 6'h20) return 4;
        if (op == 6'h21) return 5;
        return 6;
    endfunction

    function automatic bit reads_a(input int c);
        return (c >= 1 && c <= 4);
    endfunction

    function automatic bit reads_b(input int c);
        return (c == 1 || c == 3 || c == 4);
    endfunction

    function automatic logic [47:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [29:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] i);
        if (i == 4'd0) return 32'd0;
        if (wb_en_5a && wb_rd_5a == i) return wb_data_5a;
        return mregs[i];
    endfunction

    // A register is unavailable while a load that writes it sits in 2a or one stage later.
    function automatic bit pending_load(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        return (e.valid && e.cls == 2 && e.rd == r) || (m_ldv && m_ldrd == r);
    endfunction

    function automatic bit m_stall();
        int c;
        c = cls_of(instruction_1a[47:42]);
        if (!m_v1 || kill_4a) return 1'b0;
        return (reads_a(c) && pending_load(instruction_1a[37:34])) ||
               (reads_b(c) && pending_load(instruction_1a[33:30]));
    endfunction

    always @(posedge clk or negedge rst_b) begin : model
        bit    st;
        slot_t n;
        if (!rst_b) begin
            e = '{valid: 1'b0, pc: 32'd0, op: 6'd0, rd: 4'd0, rs: 4'd0, rt: 4'd0,
                  rsv: 32'd0, rtv: 32'd0, imm: 32'd0, cls: 0, wr: 1'b0};
            for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
            m_v1 = 1'b0; m_ldv = 1'b0; m_ldrd = 4'd0; m_hold = 1'b0;
        end else begin
            st = m_stall();
            n  = e;
            if (kill_4a) m_ldv = 1'b0;
            else begin
                m_ldv = e.valid && (e.cls == 2);
                if (e.valid) m_ldrd = e.rd;
            end
            if (kill_4a || st) begin
                n.valid = 1'b0; n.cls = 0; n.wr = 1'b0;
            end else begin
                n.valid = m_v1;
                n.pc    = pc_1a;
                n.op    = instruction_1a[47:42];
                n.rd    = instruction_1a[41:38];
                n.rs    = instruction_1a[37:34];
                n.rt    = instruction_1a[33:30];
                n.rsv   = mread(n.rs);
                n.rtv   = mread(n.rt);
                n.imm   = {{2{instruction_1a[29]}}, instruction_1a[29:0]};
                n.cls   = m_v1 ? cls_of(n.op) : 0;
                n.wr    = m_v1 && (n.cls == 1 || n.cls == 2) && (n.rd != 4'd0);
            end
            e = n;
            if (wb_en_5a && wb_rd_5a != 4'd0) mregs[wb_rd_5a] = wb_data_5a;
            m_v1   = 1'b1;
            m_hold = st;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_stall",  {31'd0, stall_2a},     {31'd0, m_stall()});
            cmp("m_valid",  {31'd0, valid_2a},     {31'd0, e.valid});
            cmp("m_pc",     pc_2a,                 e.pc);
            cmp("m_op",     {26'd0, opcode_2a},    {26'd0, e.op});
            cmp("m_idx",    {20'd0, rd_2a, rs_2a, rt_2a}, {20'd0, e.rd, e.rs, e.rt});
            cmp("m_rsval",  rs_val_2a,             e.rsv);
            cmp("m_rtval",  rt_val_2a,             e.rtv);
            cmp("m_imm",    imm_2a,                e.imm);
            cmp("m_flags",  {25'd0, is_alu_2a, is_load_2a, is_store_2a, is_branch_2a,
                             is_jump_2a, illegal_2a, writes_rd_2a},
                            {25'd0, e.cls == 1, e.cls == 2, e.cls == 3, e.cls == 4,
                             e.cls == 5, e.cls == 6, e.wr});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [47:0] ins, input logic [31:0] pc);
        instruction_1a = ins;
        pc_1a          = pc;
    endtask

    initial begin
        logic [5:0] rop;
        int         r;
        chk_en = 1'b0;
        rst_b = 1'b1; kill_4a = 1'b0; wb_en_5a = 1'b0; wb_rd_5a = 4'd0;
        wb_data_5a = 32'd0; set_in(48'd0, 32'd0);
        #2 rst_b = 1'b0;
        chk_en = 1'b1;
        #1;
        cmp("rst_valid", {31'd0, valid_2a}, 32'd0);
        cmp("rst_pc", pc_2a, 32'd0);
        cmp("rst_stall", {31'd0, stall_2a}, 32'd0);
        cyc(); cyc();
        rst_b = 1'b1;

        // Preload r1=5, r2=7 while NOPs flow; first valid decode on 2nd edge.
        wb_en_5a = 1'b1; wb_rd_5a = 4'd1; wb_data_5a = 32'd5;
        cyc();
        cmp("first_edge_valid", {31'd0, valid_2a}, 32'd0);
        wb_rd_5a = 4'd2; wb_data_5a = 32'd7;
        cyc();
        cmp("second_edge_valid", {31'd0, valid_2a}, 32'd1);
        wb_en_5a = 1'b0;
        set_in(enc(6'h01, 4'd3, 4'd1, 4'd2, 30'h15), 32'h100);
        cyc();
        cmp("alu_valid", {31'd0, valid_2a}, 32'd1);
        cmp("alu_rs_val", rs_val_2a, 32'd5);
        cmp("alu_rt_val", rt_val_2a, 32'd7);
        cmp("alu_wr", {31'd0, writes_rd_2a}, 32'd1);
        cmp("alu_pc", pc_2a, 32'h100);
        cmp("alu_imm", imm_2a, 32'h15);

        // Back-to-back load-use: two bubbles.
        set_in(enc(6'h10, 4'd4, 4'd1, 4'd0, 30'd0), 32'h104);
        cyc();
        set_in(enc(6'h01, 4'd5, 4'd4, 4'd0, 30'd0), 32'h108);
        #1 cmp("lu0_stall1", {31'd0, stall_2a}, 32'd1);
        cyc();
        cmp("lu0_bubble1", {31'd0, valid_2a}, 32'd0);
        #1 cmp("lu0_stall2", {31'd0, stall_2a}, 32'd1);
        cyc();
        cmp("lu0_bubble2", {31'd0, valid_2a}, 32'd0);
        #1 cmp("lu0_nostall", {31'd0, stall_2a}, 32'd0);
        cyc();
        cmp("lu0_issue", pc_2a, 32'h108);
        cmp("lu0_issue_v", {31'd0, valid_2a}, 32'd1);

        // Load, NOP, use: one bubble.
        set_in(enc(6'h10, 4'd8, 4'd0, 4'd0, 30'd0), 32'h10C);
        cyc();
        set_in(48'd0, 32'h110);
        cyc();
        set_in(enc(6'h01, 4'd9, 4'd0, 4'd8, 30'd0), 32'h114);
        #1 cmp("lu1_stall", {31'd0, stall_2a}, 32'd1);
        cyc();
        cmp("lu1_bubble", {31'd0, valid_2a}, 32'd0);
        #1 cmp("lu1_nostall", {31'd0, stall_2a}, 32'd0);
        cyc();
        cmp("lu1_issue", pc_2a, 32'h114);

        // Kill coinciding with a hazard.
        set_in(enc(6'h10, 4'd5, 4'd0, 4'd0, 30'd0), 32'h118);
        cyc();
        set_in(enc(6'h01, 4'd6, 4'd5, 4'd5, 30'd0), 32'h11C);
        kill_4a = 1'b1;
        #1 cmp("kill_stall", {31'd0, stall_2a}, 32'd0);
        cyc();
        kill_4a = 1'b0;
        cmp("kill_valid", {31'd0, valid_2a}, 32'd0);
        #1 cmp("kill_after_stall", {31'd0, stall_2a}, 32'd0);
        cyc();
        cmp("kill_issue", pc_2a, 32'h11C);

        // Write-through bypass and r0 immutability.
        wb_en_5a = 1'b1; wb_rd_5a = 4'd6; wb_data_5a = 32'hDEADBEEF;
        set_in(enc(6'h01, 4'd7, 4'd6, 4'd0, 30'd0), 32'h120);
        cyc();
        cmp("bypass", rs_val_2a, 32'hDEADBEEF);
        wb_rd_5a = 4'd0; wb_data_5a = 32'h1234;
        set_in(enc(6'h01, 4'd7, 4'd0, 4'd6, 30'd0), 32'h124);
        cyc();
        wb_en_5a = 1'b0;
        cmp("r0_zero", rs_val_2a, 32'd0);
        cmp("r6_stored", rt_val_2a, 32'hDEADBEEF);

        // Illegal opcode and negative immediate.
        set_in(enc(6'h3F, 4'd3, 4'd1, 4'd2, 30'h20000000), 32'h128);
        cyc();
        cmp("ill_flag", {31'd0, illegal_2a}, 32'd1);
        cmp("ill_classes", {27'd0, is_alu_2a, is_load_2a, is_store_2a, is_branch_2a,
                            is_jump_2a}, 32'd0);
        cmp("ill_wr", {31'd0, writes_rd_2a}, 32'd0);
        cmp("ill_imm", imm_2a, 32'hE0000000);

        // Randomized traffic; fetch holds its instruction while stalled.
        for (int k = 0; k < 500; k++) begin
            if (!m_hold) begin
                r = int'($urandom_range(0, 15));
                if (r == 0) rop = 6'h00;
                else if (r <= 5) rop = 6'($urandom_range(1, 15));
                else if (r <= 8) rop = 6'h10;
                else if (r == 9) rop = 6'h11;
                else if (r == 10) rop = 6'h20;
                else if (r == 11) rop = 6'h21;
                else if (r <= 13) rop = 6'($urandom_range(18, 31));
                else rop = 6'($urandom_range(34, 63));
                set_in(enc(rop, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                           4'($urandom_range(0, 7)), 30'($urandom)), $urandom);
            end
            kill_4a    = ($urandom_range(0, 7) == 0);
            wb_en_5a   = $urandom_range(0, 1) == 1;
            wb_rd_5a   = 4'($urandom_range(0, 15));
            wb_data_5a = $urandom;
            cyc();
        end
        kill_4a = 1'b0; wb_en_5a = 1'b0;

        // Reset asserted in the middle of a stall.
        set_in(enc(6'h10, 4'd7, 4'd0, 4'd0, 30'd0), 32'h200);
        cyc();
        set_in(enc(6'h01, 4'd1, 4'd7, 4'd0, 30'd0), 32'h204);
        #1 cmp("rs_pre_stall", {31'd0, stall_2a}, 32'd1);
        rst_b = 1'b0;
        #1;
        cmp("rs_valid", {31'd0, valid_2a}, 32'd0);
        cmp("rs_stall", {31'd0, stall_2a}, 32'd0);
        cmp("rs_pc", pc_2a, 32'd0);
        cmp("rs_load", {31'd0, is_load_2a}, 32'd0);
        cyc();
        rst_b = 1'b1;
        cyc();
        cmp("rs_edge1", {31'd0, valid_2a}, 32'd0);
        cyc();
        cmp("rs_edge2", {31'd0, valid_2a}, 32'd1);
        cmp("rs_edge2_pc", pc_2a, 32'h204);
        cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
